// File: rtl/alu_req_arbiter.sv
// Round-robin front end for one registered ALU shared by two requesters.
// One operation in flight at a time; the result returns on a single tagged response channel.
module alu_req_arbiter #(
    parameter int IN_DATA_WIDTH   = 16,
    parameter int OUT_ARITH_WIDTH = 2*IN_DATA_WIDTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       req0_valid,
    input  logic                       req1_valid,
    output logic                       req0_ready,
    output logic                       req1_ready,
    input  logic [IN_DATA_WIDTH-1:0]   req0_a,
    input  logic [IN_DATA_WIDTH-1:0]   req0_b,
    input  logic [IN_DATA_WIDTH-1:0]   req1_a,
    input  logic [IN_DATA_WIDTH-1:0]   req1_b,
    input  logic [3:0]                 req0_fun,
    input  logic [3:0]                 req1_fun,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [OUT_ARITH_WIDTH-1:0] rsp_data,
    output logic [3:0]                 rsp_flags,
    output logic                       rsp_carry,
    output logic                       rsp_err,
    output logic [IN_DATA_WIDTH-1:0]   alu_a,
    output logic [IN_DATA_WIDTH-1:0]   alu_b,
    output logic [3:0]                 alu_fun,
    input  logic [OUT_ARITH_WIDTH-1:0] alu_arith_out,
    input  logic                       alu_carry_out,
    input  logic                       alu_arith_flag,
    input  logic                       alu_logic_flag,
    input  logic                       alu_cmp_flag,
    input  logic                       alu_shift_flag,
    input  logic [IN_DATA_WIDTH-1:0]   alu_logic_out,
    input  logic [IN_DATA_WIDTH-1:0]   alu_cmp_out,
    input  logic [IN_DATA_WIDTH-1:0]   alu_shift_out,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_e;

    localparam logic [3:0] FUN_NOP = 4'b1000;
    localparam logic [3:0] FUN_DIV = 4'b0011;

    state_e                       state_q, state_d;
    logic                         last_grant_q;
    logic [3:0]                   op_fun_q;
    logic [IN_DATA_WIDTH-1:0]     alu_a_q, alu_b_q;
    logic [3:0]                   alu_fun_q;
    logic                         rsp_id_q, rsp_carry_q, rsp_err_q;
    logic [OUT_ARITH_WIDTH-1:0]   rsp_data_q;
    logic [3:0]                   rsp_flags_q;

    logic                         is_idle, grant0, grant1, accept, sel_id, sel_div0;
    logic [IN_DATA_WIDTH-1:0]     sel_a, sel_b;
    logic [3:0]                   sel_fun;
    logic [OUT_ARITH_WIDTH-1:0]   capt_data;
    logic [3:0]                   capt_flags, exp_flags;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        is_idle  = (state_q == IDLE);
        grant0   = req0_valid & (~req1_valid | last_grant_q);
        grant1   = req1_valid & (~req0_valid | ~last_grant_q);
        accept   = is_idle & (grant0 | grant1);
        sel_id   = ~grant0;
        sel_a    = sel_id ? req1_a   : req0_a;
        sel_b    = sel_id ? req1_b   : req0_b;
        sel_fun  = sel_id ? req1_fun : req0_fun;
        sel_div0 = (sel_fun == FUN_DIV) && (sel_b == '0);
    end

    always_comb begin
        capt_flags = {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag};
        exp_flags  = 4'b1000 >> op_fun_q[3:2];
        case (op_fun_q[3:2])
            2'b00:   capt_data = alu_arith_out;
            2'b01:   capt_data = OUT_ARITH_WIDTH'(alu_logic_out);
            2'b10:   capt_data = OUT_ARITH_WIDTH'(alu_cmp_out);
            default: capt_data = OUT_ARITH_WIDTH'(alu_shift_out);
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = sel_div0 ? RESP : EXEC;
            EXEC:    state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = is_idle & grant0;
        req1_ready = is_idle & grant1;
        rsp_valid  = (state_q == RESP);
        busy       = ~is_idle;
        dbg_state  = state_q;
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_fun    = alu_fun_q;
        rsp_id     = rsp_id_q;
        rsp_data   = rsp_data_q;
        rsp_flags  = rsp_flags_q;
        rsp_carry  = rsp_carry_q;
        rsp_err    = rsp_err_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_grant_q <= 1'b1;
            op_fun_q     <= FUN_NOP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= FUN_NOP;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= sel_id;
                rsp_id_q     <= sel_id;
                op_fun_q     <= sel_fun;
                // A zero divisor never reaches the ALU; the error response is built here.
                if (sel_div0) begin
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_flags_q <= '0;
                    rsp_carry_q <= 1'b0;
                end else begin
                    alu_a_q   <= sel_a;
                    alu_b_q   <= sel_b;
                    alu_fun_q <= sel_fun;
                end
            end
            if (state_q == CAPT) begin
                rsp_data_q  <= capt_data;
                rsp_flags_q <= capt_flags;
                rsp_carry_q <= alu_carry_out;
                rsp_err_q   <= (capt_flags != exp_flags);
                alu_a_q     <= '0;
                alu_b_q     <= '0;
                alu_fun_q   <= FUN_NOP;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU model, directed vectors, corner sequences
// and a randomized run against a transaction-level reference.
module tb_alu_req_arbiter;
  localparam int W  = 16;
  localparam int OW = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_fun, req1_fun;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [OW-1:0] rsp_data;
  logic [3:0]    rsp_flags;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic [OW-1:0] alu_arith_out;
  logic          alu_carry_out, alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
  logic [W-1:0]  alu_logic_out, alu_cmp_out, alu_shift_out;
  logic [1:0]    dbg_state;

  alu_req_arbiter #(.IN_DATA_WIDTH(W), .OUT_ARITH_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_fun(req0_fun), .req1_fun(req1_fun),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_arith_out(alu_arith_out), .alu_carry_out(alu_carry_out),
    .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
    .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag),
    .alu_logic_out(alu_logic_out), .alu_cmp_out(alu_cmp_out), .alu_shift_out(alu_shift_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Registered ALU model; every unit output is always computed so a wrong class select shows up.
  bit               alu_corrupt = 1'b0;
  logic signed [31:0] n_sa, n_sb, n_arith;
  logic [16:0]      n_usum;
  logic [W-1:0]     n_logic, n_cmp, n_shift;
  logic [3:0]       n_flags;
  logic             n_carry;

  always_comb begin
    n_sa   = {{16{alu_a[15]}}, alu_a};
    n_sb   = {{16{alu_b[15]}}, alu_b};
    n_usum = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_fun[1:0])
      2'd0:    n_arith = n_sa + n_sb;
      2'd1:    n_arith = n_sa - n_sb;
      2'd2:    n_arith = n_sa * n_sb;
      default: n_arith = (n_sb != 0) ? n_sa / n_sb : 32'sd0;
    endcase
    case (alu_fun[1:0])
      2'd0:    n_logic = alu_a & alu_b;
      2'd1:    n_logic = alu_a | alu_b;
      2'd2:    n_logic = ~(alu_a & alu_b);
      default: n_logic = ~(alu_a | alu_b);
    endcase
    case (alu_fun[1:0])
      2'd0:    n_cmp = 16'd0;
      2'd1:    n_cmp = (alu_a == alu_b) ? 16'd1 : 16'd0;
      2'd2:    n_cmp = (n_sa > n_sb) ? 16'd2 : 16'd0;
      default: n_cmp = (n_sa < n_sb) ? 16'd3 : 16'd0;
    endcase
    case (alu_fun[1:0])
      2'd0:    n_shift = alu_a >> 1;
      2'd1:    n_shift = alu_a << 1;
      2'd2:    n_shift = alu_b >> 1;
      default: n_shift = alu_b << 1;
    endcase
    case (alu_fun[3:2])
      2'd0:    n_flags = 4'b1000;
      2'd1:    n_flags = 4'b0100;
      2'd2:    n_flags = 4'b0010;
      default: n_flags = 4'b0001;
    endcase
    if (alu_corrupt) n_flags = 4'b0100;
    n_carry = (alu_fun == 4'b0000) & n_usum[16];
  end

  always_ff @(posedge CLK) begin
    alu_arith_out <= n_arith;
    alu_logic_out <= n_logic;
    alu_cmp_out   <= n_cmp;
    alu_shift_out <= n_shift;
    alu_carry_out <= n_carry;
    {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag} <= n_flags;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
    logic        carry;
    logic        err;
  } res_t;

  // Reference: operation semantics straight from the function-code table.
  function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    res_t r;
    int sa, sb;
    int unsigned ua, ub;
    logic [15:0] t;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    t  = 16'h0;
    r  = '{default: 0};
    case (fun)
      4'h0: begin r.data = 32'(sa + sb); r.flags = 4'b1000; r.carry = (ua + ub) > 32'hFFFF; end
      4'h1: begin r.data = 32'(sa - sb); r.flags = 4'b1000; end
      4'h2: begin r.data = 32'(sa * sb); r.flags = 4'b1000; end
      4'h3: begin
        if (b == 16'h0) r.err = 1'b1;
        else begin r.data = 32'(sa / sb); r.flags = 4'b1000; end
      end
      4'h4: begin t = a & b;    r.data = {16'h0, t}; r.flags = 4'b0100; end
      4'h5: begin t = a | b;    r.data = {16'h0, t}; r.flags = 4'b0100; end
      4'h6: begin t = ~(a & b); r.data = {16'h0, t}; r.flags = 4'b0100; end
      4'h7: begin t = ~(a | b); r.data = {16'h0, t}; r.flags = 4'b0100; end
      4'h8: begin r.data = 32'd0; r.flags = 4'b0010; end
      4'h9: begin r.data = (a == b) ? 32'd1 : 32'd0; r.flags = 4'b0010; end
      4'hA: begin r.data = (sa > sb) ? 32'd2 : 32'd0; r.flags = 4'b0010; end
      4'hB: begin r.data = (sa < sb) ? 32'd3 : 32'd0; r.flags = 4'b0010; end
      4'hC: begin t = a >> 1; r.data = {16'h0, t}; r.flags = 4'b0001; end
      4'hD: begin t = a << 1; r.data = {16'h0, t}; r.flags = 4'b0001; end
      4'hE: begin t = b >> 1; r.data = {16'h0, t}; r.flags = 4'b0001; end
      default: begin t = b << 1; r.data = {16'h0, t}; r.flags = 4'b0001; end
    endcase
    return r;
  endfunction

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    bit          corrupt;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        carry;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  task automatic set_req(input int id, input bit vld, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] fun);
    if (id == 0) begin
      req0_valid = vld; req0_a = a; req0_b = b; req0_fun = fun;
    end else begin
      req1_valid = vld; req1_a = a; req1_b = b; req1_fun = fun;
    end
  endtask

  task automatic wait_rsp(input string nm, inout int lat);
    while (!rsp_valid && lat < 12) begin
      @(negedge CLK);
      #1;
      lat++;
    end
    check({nm, "_rsp_seen"}, rsp_valid, 1);
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int lat;
    bit div0;
    div0 = (v.fun == 4'b0011) && (v.b == 16'h0);
    alu_corrupt = v.corrupt;
    @(negedge CLK);
    set_req(v.id ? 1 : 0, 1'b1, v.a, v.b, v.fun);
    set_req(v.id ? 0 : 1, 1'b0, 16'h0, 16'h0, 4'h8);
    rsp_ready = 1'b1;
    #1;
    check({nm, "_ready"}, v.id ? req1_ready : req0_ready, 1);
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat = 1;
    check({nm, "_alu_fun"}, alu_fun, div0 ? 4'b1000 : v.fun);
    wait_rsp(nm, lat);
    check({nm, "_latency"}, lat, div0 ? 1 : 3);
    check({nm, "_id"}, rsp_id, v.id);
    check({nm, "_data"}, rsp_data, v.data);
    check({nm, "_flags"}, rsp_flags, v.flags);
    check({nm, "_carry"}, rsp_carry, v.carry);
    check({nm, "_err"}, rsp_err, v.err);
    @(negedge CLK);
    #1;
    check({nm, "_idle_after"}, {busy, rsp_valid}, 0);
    alu_corrupt = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    bit v[2];
    logic [15:0] ra[2], rb[2];
    logic [3:0] rf[2];
    int m_last, m_acc, m_resp, g;
    bit m_busy, m_div0, e_r0, e_r1, e_rv, e_alu;
    logic [3:0] m_fun;
    logic [15:0] m_a, m_b;
    logic [38:0] exp_q[$];
    logic [38:0] exp_v;
    res_t r;

    vecs[0]  = '{1'b0, 16'd10,   16'd20,   4'b0000, 1'b0, 32'd30,         4'b1000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'd1,    4'b0000, 1'b0, 32'd0,          4'b1000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'd100,  16'd300,  4'b0001, 1'b0, 32'hFFFFFF38,   4'b1000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'd7,    16'd2,    4'b0011, 1'b0, 32'd3,          4'b1000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'd20,   16'd0,    4'b0011, 1'b0, 32'd0,          4'b0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'h00F0, 16'h0FF0, 4'b0100, 1'b0, 32'h000000F0,   4'b0100, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'd20,   16'd10,   4'b1010, 1'b0, 32'd2,          4'b0010, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'd5,    16'd9,    4'b1000, 1'b0, 32'd0,          4'b0010, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h8001, 16'd0,    4'b1101, 1'b0, 32'h00000002,   4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'd3,    16'h8000, 4'b1110, 1'b0, 32'h00004000,   4'b0001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'd10,   16'd20,   4'b0000, 1'b1, 32'd30,         4'b0100, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 16'hFFFB, 16'd3,    4'b1011, 1'b0, 32'd3,          4'b0010, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'd20,   16'd10,   4'b0111, 1'b0, 32'h0000FFE1,   4'b0100, 1'b0, 1'b0};

    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_fun = 4'h8; req1_fun = 4'h8;

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_alu_fun", alu_fun, 4'b1000);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    check("rst_rsp_fields", {rsp_id, rsp_carry, rsp_err, rsp_flags, rsp_data}, 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests right after reset: req0 first, then req1, then req0 again
    pulse_reset();
    @(negedge CLK);
    set_req(0, 1'b1, 16'hFFF6, 16'hFFEC, 4'b0010);
    set_req(1, 1'b1, 16'd20, 16'd10, 4'b0111);
    rsp_ready = 1'b1;
    #1;
    check("both_r0_first", req0_ready, 1);
    check("both_r1_held", req1_ready, 0);
    @(negedge CLK);
    req0_valid = 1'b0;
    #1;
    check("both_r1_busy", req1_ready, 0);
    lat = 1;
    wait_rsp("both_a", lat);
    check("both_a_latency", lat, 3);
    check("both_a_id", rsp_id, 0);
    check("both_a_data", rsp_data, 32'd200);
    check("both_a_flags", rsp_flags, 4'b1000);
    @(negedge CLK);
    #1;
    check("both_r1_second", req1_ready, 1);
    @(negedge CLK);
    req1_valid = 1'b0;
    #1;
    lat = 1;
    wait_rsp("both_b", lat);
    check("both_b_id", rsp_id, 1);
    check("both_b_data", rsp_data, 32'h0000FFE1);
    check("both_b_flags", rsp_flags, 4'b0100);
    @(negedge CLK);
    set_req(0, 1'b1, 16'd1, 16'd2, 4'b0000);
    set_req(1, 1'b1, 16'd3, 16'd4, 4'b0000);
    #1;
    check("both_again_r0", req0_ready, 1);
    check("both_again_r1", req1_ready, 0);
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat = 1;
    wait_rsp("both_c", lat);
    check("both_c_id", rsp_id, 0);
    check("both_c_data", rsp_data, 32'd3);

    // Response backpressure
    @(negedge CLK);
    set_req(0, 1'b1, 16'd20, 16'd10, 4'b1010);
    rsp_ready = 1'b0;
    #1;
    check("bp_accept", req0_ready, 1);
    @(negedge CLK);
    req0_valid = 1'b0;
    #1;
    lat = 1;
    wait_rsp("bp", lat);
    check("bp_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, 16'd1, 16'd1, 4'b0000);
      set_req(1, 1'b1, 16'd2, 16'd2, 4'b0001);
      #1;
      check($sformatf("bp_hold%0d", k), {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_data},
            {1'b1, 1'b0, 1'b0, 4'b0010, 32'd2});
      check($sformatf("bp_ready%0d", k), {req0_ready, req1_ready}, 0);
      @(negedge CLK);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    #1;
    check("bp_release_valid", rsp_valid, 1);
    @(negedge CLK);
    rsp_ready = 1'b0;
    #1;
    check("bp_idle", {busy, rsp_valid}, 0);

    // Reset while the ALU is executing
    @(negedge CLK);
    set_req(0, 1'b1, 16'd5, 16'd6, 4'b0000);
    rsp_ready = 1'b1;
    #1;
    check("mid_accept", req0_ready, 1);
    @(negedge CLK);
    req0_valid = 1'b0;
    #1;
    check("mid_exec_fun", alu_fun, 4'b0000);
    RST = 1'b0;
    #1;
    check("mid_rst_fun", alu_fun, 4'b1000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rsp_valid, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_stale", seen, 0);
    run_op('{1'b1, 16'd5, 16'd6, 4'b0000, 1'b0, 32'd11, 4'b1000, 1'b0, 1'b0}, "mid_after");

    // Randomized traffic against the transaction-level reference
    pulse_reset();
    v[0] = 1'b0; v[1] = 1'b0;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rf[0] = 4'h8; rf[1] = 4'h8;
    m_last = 1; m_busy = 1'b0; m_acc = -10; m_resp = 0; m_div0 = 1'b0;
    m_fun = 4'h8; m_a = '0; m_b = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            v[i]  = 1'b1;
            ra[i] = 16'($urandom);
            rb[i] = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            rf[i] = 4'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      set_req(0, v[0], ra[0], rb[0], rf[0]);
      set_req(1, v[1], ra[1], rb[1], rf[1]);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e_r0  = !m_busy && v[0] && (!v[1] || m_last == 1);
      e_r1  = !m_busy && v[1] && (!v[0] || m_last == 0);
      e_rv  = m_busy && (cyc >= m_resp);
      e_alu = m_busy && !m_div0 && (cyc == m_acc + 1 || cyc == m_acc + 2);
      check("rnd_ready", {req0_ready, req1_ready}, {e_r0, e_r1});
      check("rnd_busy", busy, m_busy);
      check("rnd_rsp_valid", rsp_valid, e_rv);
      check("rnd_alu_in", {alu_fun, alu_a, alu_b},
            e_alu ? {m_fun, m_a, m_b} : {4'b1000, 16'h0, 16'h0});
      if (e_rv && rsp_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 39'h0;
        check("rnd_rsp", {rsp_id, rsp_carry, rsp_err, rsp_flags, rsp_data}, exp_v);
        m_busy = 1'b0;
      end
      if (e_r0 || e_r1) begin
        g = e_r0 ? 0 : 1;
        r = ref_op(ra[g], rb[g], rf[g]);
        exp_q.push_back({1'(g), r.carry, r.err, r.flags, r.data});
        m_div0 = (rf[g] == 4'b0011) && (rb[g] == 16'h0);
        m_resp = cyc + (m_div0 ? 1 : 3);
        m_acc  = cyc;
        m_fun  = rf[g];
        m_a    = ra[g];
        m_b    = rb[g];
        m_last = g;
        m_busy = 1'b1;
        v[g]   = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Round-robin controller that shares one registered signed ALU (1-cycle result latency, unit flags {Arith, Logic, CMP, Shift}) between two requesters.
- Each requester presents A, B and ALU_FUN with a valid/ready handshake.
- The block issues one operation at a time to the ALU, captures the result selected by the function class, and returns it on a single response channel tagged with the requester id.
- It also filters divide-by-zero and checks that the returned ALU flags are consistent.

Parameters:
- IN_DATA_WIDTH, 16: operand width; matches the ALU input width.
- OUT_ARITH_WIDTH, 2*IN_DATA_WIDTH: width of the ALU arithmetic result and of rsp_data.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1 each  request present.
- req0_ready / req1_ready  out  1 each  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  IN_DATA_WIDTH  signed operands.
- req0_fun / req1_fun  in  4  ALU function code.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  OUT_ARITH_WIDTH  result.
- rsp_flags  out  4  captured {Arith, Logic, CMP, Shift} flags.
- rsp_carry  out  1  captured Carry_OUT.
- rsp_err  out  1  divide-by-zero or flag mismatch.
- alu_a, alu_b  out  IN_DATA_WIDTH  operands driven to the ALU.
- alu_fun  out  4  function code driven to the ALU.
- alu_arith_out  in  OUT_ARITH_WIDTH
- alu_carry_out  in  1
- alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag  in  1 each
- alu_logic_out, alu_cmp_out, alu_shift_out  in  IN_DATA_WIDTH
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (RST=0, async, also mid-operation):
  - state=IDLE, last_grant=1 (req0 wins the first tie).
  - alu_a=alu_b=0, alu_fun=4'b1000 (NOP).
  - rsp_valid=0; rsp_data, rsp_flags, rsp_id, rsp_carry, rsp_err all 0.
  - Any in-flight operation is dropped; no response is ever produced for it.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - reqN_ready = IDLE & reqN_valid & grantN. This is combinational, with at most one ready high.
  - Grant: single valid wins. If both are valid, the requester != last_grant wins.
  - On the accept edge: latch a, b, fun and id; update last_grant.
  - If fun==4'b0011 and b==0: go to RESP directly with rsp_err=1, rsp_data=0, rsp_flags=0, rsp_carry=0. The ALU is not issued and alu_fun stays NOP.
  - Otherwise: load alu_a, alu_b, alu_fun from the request and go to EXEC.
- EXEC: ALU inputs held stable; the ALU registers its result at the closing edge. Next state is CAPT.
- CAPT: ALU outputs valid. At the closing edge:
  - Register rsp_data by fun[3:2]:
    - 00: alu_arith_out.
    - 01: alu_logic_out, zero-extended.
    - 10: alu_cmp_out, zero-extended.
    - 11: alu_shift_out, zero-extended.
  - Register rsp_flags and rsp_carry.
  - rsp_err=1 if rsp_flags != the expected one-hot: 00→1000, 01→0100, 10→0010, 11→0001.
  - Restore alu_a=alu_b=0, alu_fun=NOP; go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_valid & rsp_ready, then IDLE.
  - Both req_ready stay 0 throughout RESP.
- Latency and throughput:
  - rsp_valid rises 2 edges after the accept edge (1 edge for divide-by-zero).
  - Minimum issue interval is 4 cycles (4'b0011 with b=0: 2 cycles).
- Requester rules and unused codes:
  - Requesters hold operands stable while valid and not ready. Dropping valid before ready is legal; no grant results.
  - fun 4'b1000 is a legal request (NOP): data 0, flags 0010.

Test Plan:
- After reset, req0 sends 10+20 (fun 0000) → accepted same cycle; 2 cycles later rsp_valid=1, id=0, data=30, flags=1000, err=0.
- req0 sends -10*-20 (0010) and req1 sends 20 NOR 10 (0111), both valid from the same cycle:
  - req0 is served first: data=200, flags=1000.
  - Then req1: data=0x0000FFE1, flags=0100.
  - Then both valid again → req0 granted (last_grant=1).
- req1 sends 20/0 (0011, b=0) → rsp_valid 1 cycle after accept, err=1, data=0, flags=0; alu_fun stays 1000 throughout.
- req0 sends 20>10 (1010) with rsp_ready held low 5 cycles → rsp_valid held, data=2 and flags=0010 stable, both req_ready=0; after rsp_ready=1, IDLE next cycle.
- Model ALU returns flags=0100 for fun 0000 → err=1, data=alu_arith_out.
- Assert RST=0 during EXEC → immediately alu_fun=1000, busy=0, rsp_valid=0; after release, no stale response and a new request is served normally.
